uart_tx_fifo: RTL and testbench

//  Transmit buffer that feeds the UART transmitter. Bus writes push bytes (plus 9th bit) into a sync FIFO.
//  A sequencer pops one entry, presents it on tx_data_reg/tx_tb8, kicks the transmitter with a 1-cycle
//  tx_ready, then waits for its completion pulse (tx_irq) before issuing the next byte.

---
 rtl/uart_tx_fifo_pkg.sv | 21 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared types and default sizing for the UART transmit buffer.
// Holds the sequencer state encoding and the default FIFO geometry.
package uart_tx_fifo_pkg;

  localparam int TXF_DEPTH = 16;
  localparam int TXF_AW    = 4;
  localparam int TXF_WIDTH = 9;

  typedef enum logic [1:0] {
    TXF_IDLE = 2'd0,
    TXF_LOAD = 2'd1,
    TXF_KICK = 2'd2,
    TXF_BUSY = 2'd3
  } txf_state_e;

  // A byte is "in flight" once the transmitter has been (or is being) kicked.
  function automatic logic txf_in_flight(input txf_state_e st);
    return (st == TXF_KICK) || (st == TXF_BUSY);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// uart_tx_fifo_sync_fifo: single-clock FIFO with AW+1-bit pointers.
// Occupancy is the pointer difference; the extra pointer bit separates full from empty.
// A synchronous clear empties the FIFO and wins over a same-cycle push or pop.
module uart_tx_fifo_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] DEPTH_LV = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  assign level   = wr_ptr_r - rd_ptr_r;
  assign full    = (level == DEPTH_LV);
  assign empty   = (level == {(AW+1){1'b0}});
  assign push_s  = wr_en && !full && !clr;
  assign pop_s   = rd_en && !empty && !clr;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update: clear resets both, otherwise advance on push/pop (wrap is implicit).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; entries are reset so the read port never shows unknown data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit buffer in front of the UART transmitter.
// Bus writes fill a FIFO of {tb8,data}; a sequencer pops one entry, presents it,
// pulses tx_ready for one cycle and waits for tx_irq (or uart_disable) before the next.
// Optional feature: define UART_TX_FIFO_THR_EN to enable the registered low-level
// threshold flag thr_irq; without it thr_irq is tied low and tx_thresh is unused.
module uart_tx_fifo #(
  parameter int DEPTH = uart_tx_fifo_pkg::TXF_DEPTH,
  parameter int AW    = uart_tx_fifo_pkg::TXF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          wr_tb8,
  input  logic          fifo_clr,
  input  logic          uart_disable,
  input  logic          tx_irq,
  output logic [7:0]    tx_data_reg,
  output logic          tx_tb8,
  output logic          tx_ready,
  output logic          tx_busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          thr_irq,
  input  logic [AW-1:0] tx_thresh
);

  import uart_tx_fifo_pkg::*;

  txf_state_e           state_r;
  txf_state_e           state_next_s;
  logic                 pop_s;
  logic [TXF_WIDTH-1:0] head_s;
  logic                 full_s;
  logic                 empty_s;
  logic [AW:0]          level_s;
  logic                 overflow_r;
  logic [7:0]           tx_data_r;
  logic                 tx_tb8_r;

  uart_tx_fifo_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (TXF_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (fifo_clr),
    .wr_en   (wr_en),
    .wr_data ({wr_tb8, wr_data}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (level_s)
  );

  assign full        = full_s;
  assign empty       = empty_s;
  assign level       = level_s;
  assign overflow    = overflow_r;
  assign tx_data_reg = tx_data_r;
  assign tx_tb8      = tx_tb8_r;
  // The kick is suppressed whenever the transmitter is being disabled.
  assign tx_ready    = (state_r == TXF_KICK) && !uart_disable;
  assign tx_busy     = txf_in_flight(state_r);

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= TXF_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next state and pop request.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      TXF_IDLE: begin
        if (!empty_s && !uart_disable) begin
          state_next_s = TXF_LOAD;
        end else begin
          state_next_s = TXF_IDLE;
        end
      end
      TXF_LOAD: begin
        // A flush between IDLE and LOAD can leave nothing to send; go back quietly.
        if (!empty_s) begin
          pop_s        = 1'b1;
          state_next_s = TXF_KICK;
        end else begin
          state_next_s = TXF_IDLE;
        end
      end
      TXF_KICK: begin
        state_next_s = TXF_BUSY;
      end
      TXF_BUSY: begin
        if (tx_irq || uart_disable) begin
          state_next_s = TXF_IDLE;
        end else begin
          state_next_s = TXF_BUSY;
        end
      end
      default: begin
        state_next_s = TXF_IDLE;
      end
    endcase
  end

  // Presented byte: captured only on a pop, held through KICK and BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_r <= 8'h00;
      tx_tb8_r  <= 1'b0;
    end else if (pop_s) begin
      tx_data_r <= head_s[7:0];
      tx_tb8_r  <= head_s[8];
    end
  end

  // Sticky overflow: set by a write into a full FIFO, cleared only by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (fifo_clr) begin
      overflow_r <= 1'b0;
    end else if (wr_en && full_s) begin
      overflow_r <= 1'b1;
    end
  end

`ifdef UART_TX_FIFO_THR_EN
  logic thr_irq_r;

  // Low-water flag, refreshed every cycle and masked while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_irq_r <= 1'b0;
    end else begin
      thr_irq_r <= (level_s <= {1'b0, tx_thresh}) && !uart_disable;
    end
  end

  assign thr_irq = thr_irq_r;
`else
  logic unused_thresh_s;

  assign unused_thresh_s = ^tx_thresh;
  assign thr_irq         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized stimulus for uart_tx_fifo, compared every
// cycle against a queue-based reference of the buffer and its issue pipeline.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          wr_tb8;
  logic          fifo_clr;
  logic          uart_disable;
  logic          tx_irq;
  logic [AW-1:0] tx_thresh;
  logic [7:0]    tx_data_reg;
  logic          tx_tb8;
  logic          tx_ready;
  logic          tx_busy;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          thr_irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: FIFO contents as a queue, plus the pending pop/kick/wait of the issuer.
  logic [8:0] m_q[$];
  bit         m_ov;
  bit         m_pop_pend;
  bit         m_kick_pend;
  bit         m_wait;
  logic [8:0] m_out;
  bit         m_thr;

  int         ready_cycs[$];
  logic [7:0] ready_data[$];
  int         irq_cycs[$];

  bit resp_en    = 1'b1;
  bit resp_rand  = 1'b0;
  bit spur_en    = 1'b0;
  int resp_delay = 20;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_tb8       (wr_tb8),
    .fifo_clr     (fifo_clr),
    .uart_disable (uart_disable),
    .tx_irq       (tx_irq),
    .tx_data_reg  (tx_data_reg),
    .tx_tb8       (tx_tb8),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .thr_irq      (thr_irq),
    .tx_thresh    (tx_thresh)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ov        = 1'b0;
    m_pop_pend  = 1'b0;
    m_kick_pend = 1'b0;
    m_wait      = 1'b0;
    m_out       = 9'h000;
    m_thr       = 1'b0;
  endtask

  // Advance the model by one cycle using the inputs that were applied during it.
  task automatic model_step();
    int sz;
    bit do_pop;
    sz     = m_q.size();
    do_pop = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      m_thr = (sz <= int'(tx_thresh)) && !uart_disable;
      if (m_wait) begin
        if (tx_irq) irq_cycs.push_back(cyc);
        if (tx_irq || uart_disable) m_wait = 1'b0;
      end else if (m_kick_pend) begin
        m_kick_pend = 1'b0;
        m_wait      = 1'b1;
      end else if (m_pop_pend) begin
        m_pop_pend = 1'b0;
        if (sz > 0) begin
          do_pop      = 1'b1;
          m_out       = m_q[0];
          m_kick_pend = 1'b1;
        end
      end else if (sz > 0 && !uart_disable) begin
        m_pop_pend = 1'b1;
      end
      if (fifo_clr) begin
        m_q.delete();
        m_ov = 1'b0;
      end else begin
        if (do_pop) void'(m_q.pop_front());
        if (wr_en) begin
          if (sz == DEPTH) m_ov = 1'b1;
          else m_q.push_back({wr_tb8, wr_data});
        end
      end
    end
  endtask

  task automatic compare_outputs();
    int         sz;
    bit         e_ready, e_busy, e_ov, e_thr;
    logic [8:0] e_out;
    if (reset) begin
      sz = 0; e_ready = 1'b0; e_busy = 1'b0; e_ov = 1'b0; e_thr = 1'b0; e_out = 9'h000;
    end else begin
      sz      = m_q.size();
      e_ready = m_kick_pend && !uart_disable;
      e_busy  = m_kick_pend || m_wait;
      e_ov    = m_ov;
      e_out   = m_out;
`ifdef UART_TX_FIFO_THR_EN
      e_thr   = m_thr;
`else
      e_thr   = 1'b0;
`endif
    end
    check_eq("level",    level,       sz);
    check_eq("full",     full,        sz == DEPTH);
    check_eq("empty",    empty,       sz == 0);
    check_eq("overflow", overflow,    e_ov);
    check_eq("tx_ready", tx_ready,    e_ready);
    check_eq("tx_busy",  tx_busy,     e_busy);
    check_eq("tx_data",  tx_data_reg, e_out[7:0]);
    check_eq("tx_tb8",   tx_tb8,      e_out[8]);
    check_eq("thr_irq",  thr_irq,     e_thr);
    if (!reset && tx_ready) begin
      ready_cycs.push_back(cyc);
      ready_data.push_back(tx_data_reg);
    end
  endtask

  // Monitor: model advances on the rising edge, outputs are compared on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      compare_outputs();
    end
  end

  // Transmitter stand-in: answers each tx_ready with a tx_irq pulse some cycles later.
  initial begin
    int irq_cnt;
    irq_cnt = 0;
    tx_irq  = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_ready && resp_en) irq_cnt = resp_rand ? int'($urandom_range(15, 1)) : resp_delay;
      @(posedge clk);
      #1;
      tx_irq = 1'b0;
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) tx_irq = 1'b1;
      end else if (spur_en && ($urandom_range(39, 0) == 0)) begin
        tx_irq = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic b8);
    wr_en = 1'b1; wr_data = d; wr_tb8 = b8;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(input int max, input string tag);
    int k;
    k = 0;
    while (!tx_ready && k < max) begin
      step();
      k++;
    end
    check_eq(tag, tx_ready, 1'b1);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k;
    k = 0;
    while ((tx_busy || !empty) && k < max) begin
      step();
      k++;
    end
    check_eq(tag, tx_busy || !empty, 1'b0);
  endtask

  task automatic clear_records();
    ready_cycs.delete();
    ready_data.delete();
    irq_cycs.delete();
  endtask

  initial begin
    int push_cyc;
    int rate;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_tb8 = 1'b0;
    fifo_clr = 1'b0; uart_disable = 1'b0; tx_thresh = 4'd2;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single byte into an empty FIFO.
    clear_records();
    push_cyc = cyc;
    push(8'hA5, 1'b1);
    repeat (6) step();
    check_eq("t1_ready_count", ready_cycs.size(), 1);
    if (ready_cycs.size() > 0) check_eq("t1_latency", ready_cycs[0] - push_cyc, 3);
    check_eq("t1_data", tx_data_reg, 8'hA5);
    check_eq("t1_tb8", tx_tb8, 1'b1);
    check_eq("t1_level", level, 0);
    wait_idle(60, "t1_idle");

    // Three bytes, transmitter answers 20 cycles after each kick.
    clear_records();
    push(8'h11, 1'b0);
    push(8'h22, 1'b1);
    push(8'h33, 1'b0);
    wait_idle(120, "t2_idle");
    check_eq("t2_ready_count", ready_cycs.size(), 3);
    if (ready_data.size() == 3) begin
      check_eq("t2_byte0", ready_data[0], 8'h11);
      check_eq("t2_byte1", ready_data[1], 8'h22);
      check_eq("t2_byte2", ready_data[2], 8'h33);
    end
    for (int i = 0; i < 2; i++) begin
      if (irq_cycs.size() > i && ready_cycs.size() > i + 1)
        check_eq($sformatf("t2_gap%0d", i), ready_cycs[i+1] - irq_cycs[i], 3);
    end

    // Overfill with the sequencer held off, then flush.
    uart_disable = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(i * 7 + 3), 1'(i));
    step();
    check_eq("t3_level", level, 16);
    check_eq("t3_full", full, 1'b1);
    check_eq("t3_overflow", overflow, 1'b1);
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    check_eq("t3_clr_level", level, 0);
    check_eq("t3_clr_empty", empty, 1'b1);
    check_eq("t3_clr_overflow", overflow, 1'b0);

    // Abort an in-flight byte with uart_disable, then resume.
    uart_disable = 1'b0;
    resp_en = 1'b0;
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b1);
    wait_ready(10, "t4_first_kick");
    repeat (3) step();
    check_eq("t4_busy", tx_busy, 1'b1);
    uart_disable = 1'b1;
    step();
    check_eq("t4_abort", tx_busy, 1'b0);
    uart_disable = 1'b0;
    wait_ready(10, "t4_next_kick");
    check_eq("t4_next_data", tx_data_reg, 8'hC3);
    resp_en = 1'b1;
    resp_delay = 4;
    wait_idle(40, "t4_idle");

    // Write colliding with the LOAD pop, at full and at level 5.
    uart_disable = 1'b1;
    for (int i = 0; i < 16; i++) push(8'($urandom), 1'($urandom));
    uart_disable = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'hEE; wr_tb8 = 1'b1;
    step();
    wr_en = 1'b0;
    check_eq("t5_full_level", level, 15);
    check_eq("t5_full_overflow", overflow, 1'b1);
    wait_idle(300, "t5_drain");
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    uart_disable = 1'b1;
    for (int i = 0; i < 5; i++) push(8'($urandom), 1'($urandom));
    uart_disable = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h77; wr_tb8 = 1'b0;
    step();
    wr_en = 1'b0;
    check_eq("t5_level_keep", level, 5);
    check_eq("t5_no_overflow", overflow, 1'b0);
    wait_idle(200, "t5_drain2");

    // Reset in the middle of a transmission.
    resp_en = 1'b0;
    push(8'h9C, 1'b1);
    push(8'h3E, 1'b0);
    wait_ready(10, "t6_kick");
    repeat (2) step();
    reset = 1'b1;
    #1;
    check_eq("t6_rst_busy", tx_busy, 1'b0);
    check_eq("t6_rst_empty", empty, 1'b1);
    check_eq("t6_rst_data", tx_data_reg, 8'h00);
    repeat (2) step();
    reset = 1'b0;
    resp_en = 1'b1;
    step();

    // Randomized traffic.
    resp_rand = 1'b1;
    spur_en   = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      rate = int'($urandom_range(60, 5));
      for (int i = 0; i < 500; i++) begin
        wr_en    = ($urandom_range(99, 0) < rate);
        wr_data  = 8'($urandom);
        wr_tb8   = 1'($urandom);
        fifo_clr = ($urandom_range(99, 0) == 0);
        if ($urandom_range(49, 0) == 0) uart_disable = ~uart_disable;
        tx_thresh = 4'($urandom);
        step();
      end
    end
    wr_en = 1'b0; fifo_clr = 1'b0; uart_disable = 1'b0; spur_en = 1'b0;
    wait_idle(600, "final_drain");
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
